// File: rtl/resp_pkg.sv
// Shared constants and FSM state type for the response serializer.
// Flag positions describe the 64-bit response word layout.
package resp_pkg;

  localparam int RESP_WIDTH    = 64;
  localparam int BEAT_WIDTH    = 32;

  localparam int FLAG_PRESENT  = 63;
  localparam int FLAG_NOTFOUND = 62;
  localparam int FLAG_NOSPACE  = 61;
  localparam int FLAG_NODEL    = 60;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_e;

endpackage

// File: rtl/resp_fifo.sv
// Synchronous circular-buffer FIFO with extended-pointer full/empty detection.
// Exposes both the head entry and the one behind it so the reader can chain words.
module resp_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [WIDTH-1:0] next_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      rd_next;
  logic             do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign rd_next = rd_ptr_q + (AW+1)'(1);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign next_o  = mem_q[rd_next[AW-1:0]];

  assign wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_next : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read between pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/response_serializer.sv
// Buffers 64-bit response words and emits each as two 32-bit AXI-Stream beats.
// Define RESP_STATS_EN to add saturating per-flag event counters.
module response_serializer
  import resp_pkg::*;
#(
  parameter int DATA_WIDTH = 25,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16,
  localparam int OCC_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [RESP_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [BEAT_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready,
  output logic [OCC_W-1:0]      occupancy_o
`ifdef RESP_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  cnt_present_o,
  output logic [CNT_WIDTH-1:0]  cnt_notfound_o,
  output logic [CNT_WIDTH-1:0]  cnt_nospace_o,
  output logic [CNT_WIDTH-1:0]  cnt_nodel_o
`endif
);

  if (DATA_WIDTH < 1 || DATA_WIDTH > 60) begin : g_bad_data_width
    $error("response_serializer: DATA_WIDTH must be 1..60");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("response_serializer: FIFO_DEPTH must be a power of two >= 2");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("response_serializer: CNT_WIDTH must be >= 1");
  end

  // Bits outside the flags and read-data field are forced to zero on entry.
  localparam logic [RESP_WIDTH-1:0] WORD_MASK =
      (RESP_WIDTH'(1) << FLAG_PRESENT)  | (RESP_WIDTH'(1) << FLAG_NOTFOUND) |
      (RESP_WIDTH'(1) << FLAG_NOSPACE)  | (RESP_WIDTH'(1) << FLAG_NODEL)    |
      ((RESP_WIDTH'(1) << DATA_WIDTH) - RESP_WIDTH'(1));

  logic [RESP_WIDTH-1:0] word_in;
  logic [RESP_WIDTH-1:0] fifo_head, fifo_next;
  logic                  fifo_full, fifo_empty;
  logic [OCC_W-1:0]      fifo_count;
  logic                  push, pop;

  state_e                state_q, state_d;
  logic [RESP_WIDTH-1:0] word_q, word_d;

  assign word_in     = data_i & WORD_MASK;
  assign ready_o     = !fifo_full;
  assign push        = valid_i && ready_o;
  assign occupancy_o = fifo_count;

  resp_fifo #(
    .WIDTH (RESP_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (word_in),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .next_o  (fifo_next),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
    end
  end

  // The head stays in the FIFO until its upper beat handshakes, so occupancy
  // includes the word in flight and the follow-on word sits one slot behind.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          word_d  = fifo_head;
          state_d = LO;
        end
      end
      LO: begin
        if (m_tready) begin
          state_d = HI;
        end
      end
      HI: begin
        if (m_tready) begin
          pop = 1'b1;
          if (fifo_count > OCC_W'(1)) begin
            word_d  = fifo_next;
            state_d = LO;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tdata  = '0;
    case (state_q)
      LO: begin
        m_tvalid = 1'b1;
        m_tdata  = word_q[BEAT_WIDTH-1:0];
      end
      HI: begin
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        m_tdata  = word_q[RESP_WIDTH-1:BEAT_WIDTH];
      end
      default: ;
    endcase
  end

`ifdef RESP_STATS_EN
  // Index order: 3 present, 2 not-found, 1 no-space, 0 no-deletion-target.
  logic [3:0]           flags;
  logic [CNT_WIDTH-1:0] cnt_q [4];

  assign flags = {word_in[FLAG_PRESENT], word_in[FLAG_NOTFOUND],
                  word_in[FLAG_NOSPACE], word_in[FLAG_NODEL]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (push) begin
      for (int i = 0; i < 4; i++) begin
        if (flags[i] && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign cnt_present_o  = cnt_q[3];
  assign cnt_notfound_o = cnt_q[2];
  assign cnt_nospace_o  = cnt_q[1];
  assign cnt_nodel_o    = cnt_q[0];
`endif

endmodule

// File: tb/tb_response_serializer.sv
// Scoreboard bench for response_serializer; RESP_STATS_EN enables the counter checks.
module tb_response_serializer;

  logic        clk;
  logic        reset;
  logic [63:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;
  logic [2:0]  occupancy_o;
`ifdef RESP_STATS_EN
  logic [1:0]  cnt_present_o, cnt_notfound_o, cnt_nospace_o, cnt_nodel_o;
`endif

  int errors = 0;
  int checks = 0;
  logic [32:0] sb_q [$];

  response_serializer #(
    .DATA_WIDTH (25),
    .FIFO_DEPTH (4),
    .CNT_WIDTH  (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .data_i         (data_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .m_tdata        (m_tdata),
    .m_tvalid       (m_tvalid),
    .m_tlast        (m_tlast),
    .m_tready       (m_tready),
    .occupancy_o    (occupancy_o)
`ifdef RESP_STATS_EN
    ,
    .cnt_present_o  (cnt_present_o),
    .cnt_notfound_o (cnt_notfound_o),
    .cnt_nospace_o  (cnt_nospace_o),
    .cnt_nodel_o    (cnt_nodel_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen between edges completes at the next rising edge.
  always @(negedge clk) begin
    if (reset && m_tvalid && m_tready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got data %h last %b expected no beat", m_tdata, m_tlast);
      end else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        if ({m_tlast, m_tdata} !== e) begin
          errors++;
          $display("FAIL beat: got last %b data %h expected last %b data %h",
                   m_tlast, m_tdata, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] din, input logic [63:0] dexp);
    data_i  = din;
    valid_i = 1'b1;
    for (int t = 0; t < 64; t++) begin
      if (ready_o) begin
        @(posedge clk);
        sb_q.push_back({1'b0, dexp[31:0]});
        sb_q.push_back({1'b1, dexp[63:32]});
        #1;
        valid_i = 1'b0;
        return;
      end
      tick();
    end
    valid_i = 1'b0;
    check("push_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    m_tready = 1'b1;
    for (int t = 0; t < 60; t++) begin
      if (sb_q.size() == 0 && !m_tvalid) break;
      tick();
    end
    check("drain_queue_empty", 64'(sb_q.size()), 64'd0);
    check("drain_tvalid_low", 64'(m_tvalid), 64'd0);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    sb_q.delete();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] prev_data;
    logic        prev_last, prev_valid, prev_ready;
    reset    = 1'b0;
    valid_i  = 1'b0;
    data_i   = '0;
    m_tready = 1'b0;
    tick();
    tick();
    reset = 1'b1;

    // Reset state and single word
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tlast", 64'(m_tlast), 64'd0);
    check("rst_tdata", 64'(m_tdata), 64'd0);
    check("rst_occ", 64'(occupancy_o), 64'd0);
    m_tready = 1'b1;
    push(64'h8000_0000_0123_4567, 64'h8000_0000_0123_4567);
    check("t1_not_yet_valid", 64'(m_tvalid), 64'd0);
    check("t1_occ_after_push", 64'(occupancy_o), 64'd1);
    tick();
    check("t1_lo_valid", 64'(m_tvalid), 64'd1);
    check("t1_lo_data", 64'(m_tdata), 64'h0123_4567);
    check("t1_lo_last", 64'(m_tlast), 64'd0);
    tick();
    check("t1_hi_data", 64'(m_tdata), 64'h8000_0000);
    check("t1_hi_last", 64'(m_tlast), 64'd1);
    check("t1_hi_occ", 64'(occupancy_o), 64'd1);
    tick();
    check("t1_idle_valid", 64'(m_tvalid), 64'd0);
    check("t1_idle_occ", 64'(occupancy_o), 64'd0);

    // Fill to full under backpressure
    m_tready = 1'b0;
    push(64'h0000_0000_0000_0011, 64'h0000_0000_0000_0011);
    push(64'h2000_0000_0000_0022, 64'h2000_0000_0000_0022);
    push(64'h0000_0000_01AB_CDEF, 64'h0000_0000_01AB_CDEF);
    check("t2_ready_before_full", 64'(ready_o), 64'd1);
    push(64'h1000_0000_0000_0044, 64'h1000_0000_0000_0044);
    check("t2_ready_full", 64'(ready_o), 64'd0);
    check("t2_occ_full", 64'(occupancy_o), 64'd4);
    data_i  = 64'h0000_0000_0000_0055;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    check("t2_fifth_rejected_occ", 64'(occupancy_o), 64'd4);
    m_tready = 1'b1;
    tick();
    check("t2_after_lo_ready", 64'(ready_o), 64'd0);
    check("t2_after_lo_last", 64'(m_tlast), 64'd1);
    tick();
    check("t2_after_hi_ready", 64'(ready_o), 64'd1);
    check("t2_after_hi_occ", 64'(occupancy_o), 64'd3);
    check("t2_after_hi_data", 64'(m_tdata), 64'h0000_0022);
    drain();

    // Back-to-back words with the sink always ready
    m_tready = 1'b1;
    fork
      begin
        push(64'h0FFF_FFFF_FFFF_FFFF, 64'h0000_0000_01FF_FFFF);
        push(64'hC000_0000_0000_0101, 64'hC000_0000_0000_0101);
        push(64'h0000_0000_0000_0202, 64'h0000_0000_0000_0202);
      end
      begin
        int waited;
        waited = 0;
        while (!m_tvalid && waited < 10) begin
          tick();
          waited++;
        end
        for (int k = 0; k < 6; k++) begin
          check($sformatf("t3_b2b_valid_%0d", k), 64'(m_tvalid), 64'd1);
          check($sformatf("t3_b2b_last_%0d", k), 64'(m_tlast), 64'(k % 2));
          tick();
        end
        check("t3_b2b_end_valid", 64'(m_tvalid), 64'd0);
      end
    join
    drain();

    // Toggling backpressure across two words
    m_tready = 1'b0;
    push(64'h2000_0000_0000_00AA, 64'h2000_0000_0000_00AA);
    push(64'h1000_0000_0155_5555, 64'h1000_0000_0155_5555);
    for (int i = 0; i < 12; i++) begin
      m_tready   = (i % 2 == 1);
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      prev_valid = m_tvalid;
      prev_ready = m_tready;
      tick();
      if (prev_valid && !prev_ready) begin
        check($sformatf("t4_stall_data_%0d", i), 64'(m_tdata), 64'(prev_data));
        check($sformatf("t4_stall_last_%0d", i), 64'(m_tlast), 64'(prev_last));
        check($sformatf("t4_stall_valid_%0d", i), 64'(m_tvalid), 64'd1);
      end
    end
    check("t4_all_sent_queue", 64'(sb_q.size()), 64'd0);
    check("t4_all_sent_valid", 64'(m_tvalid), 64'd0);

    // Reset while the upper beat is pending
    m_tready = 1'b0;
    push(64'h4000_0000_0000_0C0C, 64'h4000_0000_0000_0C0C);
    push(64'h8000_0000_0000_0D0D, 64'h8000_0000_0000_0D0D);
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    check("t5_in_hi_last", 64'(m_tlast), 64'd1);
    check("t5_in_hi_occ", 64'(occupancy_o), 64'd2);
    apply_reset();
    check("t5_rst_valid", 64'(m_tvalid), 64'd0);
    check("t5_rst_occ", 64'(occupancy_o), 64'd0);
    check("t5_rst_ready", 64'(ready_o), 64'd1);
    m_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("t5_no_stale_%0d", i), 64'(m_tvalid), 64'd0);
    end

`ifdef RESP_STATS_EN
    apply_reset();
    check("st_rst_notfound", 64'(cnt_notfound_o), 64'd0);
    m_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(64'h4000_0000_0000_0000 | 64'(i), 64'h4000_0000_0000_0000 | 64'(i));
    end
    check("st_notfound_sat", 64'(cnt_notfound_o), 64'd3);
    check("st_present_zero", 64'(cnt_present_o), 64'd0);
    push(64'h9000_0000_0000_0001, 64'h9000_0000_0000_0001);
    check("st_present_inc", 64'(cnt_present_o), 64'd1);
    check("st_nodel_inc", 64'(cnt_nodel_o), 64'd1);
    check("st_nospace_zero", 64'(cnt_nospace_o), 64'd0);
    check("st_notfound_hold", 64'(cnt_notfound_o), 64'd3);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/response_serializer.md
Name: response_serializer

Overview:
- Downstream stage of the hash-table AXI wrapper.
- Accepts 64-bit response words (read data plus the four status flags) over valid/ready and buffers them in a small FIFO.
- Emits each word as two 32-bit AXI-Stream beats (low half, then high half with tlast) toward the DMA/host interface.
- Optionally keeps saturating per-flag event counters for software.

Parameters:
- DATA_WIDTH, 25, width of the read-data field in bits [DATA_WIDTH-1:0]; must be ≤ 60.
- FIFO_DEPTH, 4, number of buffered response words; power of two, ≥ 2.
- CNT_WIDTH, 16, width of each status counter (used only with RESP_STATS_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- data_i  in  64  response word: [63] key_already_present, [62] no_element_found, [61] no_write_space, [60] no_deletion_target, [DATA_WIDTH-1:0] read data, other bits zero.
- valid_i  in  1  data_i valid.
- ready_o  out  1  block can accept data_i.
- m_tdata  out  32  output beat.
- m_tvalid  out  1  m_tdata valid.
- m_tlast  out  1  high on the second (upper-half) beat.
- m_tready  in  1  sink ready.
- occupancy_o  out  clog2(FIFO_DEPTH)+1  words currently held, including the one being sent.
- cnt_present_o, cnt_notfound_o, cnt_nospace_o, cnt_nodel_o  out  CNT_WIDTH each  flag counters; present only with RESP_STATS_EN.

Behaviour:
- Reset (reset==0 at a clk edge):
  - FIFO empty, pointers 0, occupancy_o=0, FSM in IDLE.
  - m_tvalid=0, m_tlast=0, m_tdata=0.
  - ready_o=1 from the first cycle after reset release.
  - Counters cleared.
  - Reset mid-transfer discards buffered words and any half-sent word; no tlast beat is emitted afterwards for that word.
- Input handshake:
  - Push when valid_i && ready_o.
  - ready_o = !full, registered-equivalent: it depends on the FIFO state only, never on valid_i.
  - When full, ready_o=0. There is no same-cycle push/pop bypass, so a pop while full raises ready_o only in the next cycle.
- FIFO:
  - Circular buffer of FIFO_DEPTH×64.
  - Read/write pointers are clog2(FIFO_DEPTH)+1 bits; the MSB disambiguates full from empty.
  - Pointers wrap naturally.
  - Simultaneous push and pop when neither full nor empty: occupancy unchanged.
- Output FSM, states IDLE, LO, HI:
  - IDLE: if the FIFO is non-empty, load the head word into the output register and go to LO. A word pushed at edge N is visible on m_tvalid at edge N+1 (latency 1 from an empty FIFO).
  - LO: m_tvalid=1, m_tdata=word[31:0], m_tlast=0. On m_tready go to HI.
  - HI: m_tvalid=1, m_tdata=word[63:32], m_tlast=1.
    - On m_tready: pop the head.
    - If the FIFO still holds another word after the pop, load it and go straight to LO (back-to-back, no bubble).
    - Otherwise go to IDLE.
- AXI-Stream rules:
  - m_tdata, m_tlast and m_tvalid are held stable while m_tvalid && !m_tready.
  - m_tvalid never drops without a handshake.
- occupancy_o counts the word being serialised until its HI beat handshakes.

Optional Feature:
- Macro RESP_STATS_EN.
- Defined:
  - Each push increments every counter whose flag bit is 1 in data_i.
  - Counters saturate at all-ones.
  - Counter ports exist; counters clear on reset.
- Not defined: counter ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package resp_pkg holds:
  - flag bit-position localparams (FLAG_PRESENT=63, FLAG_NOTFOUND=62, FLAG_NOSPACE=61, FLAG_NODEL=60);
  - RESP_WIDTH=64 and BEAT_WIDTH=32;
  - the FSM state enum {IDLE, LO, HI}.
- One natural sub-module: resp_fifo (parameterised synchronous FIFO with push/pop/full/empty/count), instantiated once; the serializer FSM and counters live in the top.

Test Plan:
- Reset release with sink idle → ready_o=1, m_tvalid=0, occupancy_o=0. Push 64'h8000_0000_0123_4567 → next cycle m_tvalid=1, m_tdata=32'h0123_4567, m_tlast=0. With m_tready=1, the next beat is 32'h8000_0000 with m_tlast=1, then m_tvalid=0.
- m_tready=0, push 5 words with FIFO_DEPTH=4 → ready_o=0 after the 4th push and the 5th is not accepted. One HI handshake → ready_o=1 the following cycle.
- Three words pushed with m_tready held 1 → six consecutive beats, tlast pattern 0,1,0,1,0,1, no idle cycle between words.
- Backpressure: m_tready toggles 0/1 every cycle during LO and HI → m_tdata and m_tlast stay stable while stalled, and each half is transferred exactly once.
- reset=0 for one cycle while in HI with 2 words buffered → next cycle m_tvalid=0, occupancy_o=0, and no stale beat appears afterwards.
- RESP_STATS_EN, CNT_WIDTH=2:
  - Push 5 words with bit 62 set → cnt_notfound_o saturates at 3.
  - A word with bits 63 and 60 set → cnt_present_o and cnt_nodel_o each increment by 1.
